// File: rtl/down_timer.sv
// Programmable down-counter with prescaler, one-shot / auto-reload modes, pause and abort.
// Latency: start sampled at edge N -> busy from N+1; first decrement visible pre_reg+1 cycles later.
// Backpressure: load_ready is high only in IDLE; load_* presented while busy are dropped.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   load_valid / load_ready   configuration handshake (value, prescale-1, auto-reload select)
//   start, stop               per-cycle run / abort requests; pause is a level hold request
//   count                     registered current count
//   busy                      high in RUN or HOLD
//   tick, done                one-cycle registered pulses: per decrement / on terminal count
module down_timer #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WIDTH-1:0]     load_value,
  input  logic [PRE_WIDTH-1:0] load_prescale,
  input  logic                 load_auto,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
  localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     count_nxt;
  logic [WIDTH-1:0]     reload_reg, reload_nxt;
  logic [PRE_WIDTH-1:0] pre_reg, pre_nxt;
  logic [PRE_WIDTH-1:0] pre_cnt, pre_cnt_nxt;
  logic                 auto_reg, auto_nxt;
  logic                 done_nxt, tick_nxt;
  logic                 load_acc;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign load_acc   = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      pre_reg    <= '0;
      auto_reg   <= 1'b0;
      pre_cnt    <= '0;
      done       <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      pre_reg    <= pre_nxt;
      auto_reg   <= auto_nxt;
      pre_cnt    <= pre_cnt_nxt;
      done       <= done_nxt;
      tick       <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    reload_nxt  = reload_reg;
    pre_nxt     = pre_reg;
    auto_nxt    = auto_reg;
    pre_cnt_nxt = pre_cnt;
    done_nxt    = 1'b0;
    tick_nxt    = 1'b0;

    case (state)
      IDLE: begin
        // Prescaler is held at zero so every RUN entry starts a fresh period.
        pre_cnt_nxt = '0;
        if (load_acc) begin
          count_nxt  = load_value;
          reload_nxt = load_value;
          pre_nxt    = load_prescale;
          auto_nxt   = load_auto;
        end else if (start && (count != '0)) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_nxt   = IDLE;
          pre_cnt_nxt = '0;
        end else if (pause) begin
          // The pause cycle itself makes no prescaler progress.
          state_nxt = HOLD;
        end else if (pre_cnt == pre_reg) begin
          pre_cnt_nxt = '0;
          tick_nxt    = 1'b1;
          if (count == CNT_ONE) begin
            done_nxt = 1'b1;
            if (auto_reg) begin
              count_nxt = reload_reg;
            end else begin
              count_nxt = '0;
              state_nxt = IDLE;
            end
          end else if (count != '0) begin
            // count==0 cannot be running; the guard keeps the counter from wrapping.
            count_nxt = count - CNT_ONE;
          end
        end else begin
          pre_cnt_nxt = pre_cnt + PRE_ONE;
        end
      end

      HOLD: begin
        if (stop) begin
          state_nxt   = IDLE;
          pre_cnt_nxt = '0;
        end else if (!pause) begin
          // Resume with pre_cnt intact; the release cycle makes no progress.
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt   = IDLE;
        pre_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus a randomized run
// against a period-based behavioural model.
module tb_down_timer;

  localparam int W = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic [P-1:0] load_prescale;
  logic         load_auto;
  logic         start;
  logic         pause;
  logic         stop;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W), .PRE_WIDTH(P)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .load_prescale (load_prescale),
    .load_auto     (load_auto),
    .start         (start),
    .pause         (pause),
    .stop          (stop),
    .count         (count),
    .busy          (busy),
    .done          (done),
    .tick          (tick)
  );

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid    = 1'b0;
    load_value    = '0;
    load_prescale = '0;
    load_auto     = 1'b0;
    start         = 1'b0;
    pause         = 1'b0;
    stop          = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic [P-1:0] p, input logic a);
    load_valid    = 1'b1;
    load_value    = v;
    load_prescale = p;
    load_auto     = a;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    load_valid = 1'b1;
    load_value = 8'hA5;
    start      = 1'b1;
    pause      = 1'b1;
    step();
    step();
    total++; if (count !== '0)       begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (tick !== 1'b0)      begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    rst = 1'b0;
    idle_inputs();
    // start with count==0 after reset must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_zero busy got=%b exp=0", busy); end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] exp_cnt [1:5];
    logic         exp_dn  [1:5];
    logic         exp_bs  [1:5];
    logic         exp_tk  [1:5];
    exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    exp_dn  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_bs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_tk  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_load(8'd3, 4'd0, 1'b0);
    total++; if (count !== 8'd3) begin bad++; $display("FAIL oneshot_load count got=%0d exp=3", count); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      total++; if (count !== exp_cnt[j]) begin bad++; $display("FAIL oneshot_count j=%0d got=%0d exp=%0d", j, count, exp_cnt[j]); end
      total++; if (done !== exp_dn[j])   begin bad++; $display("FAIL oneshot_done j=%0d got=%b exp=%b", j, done, exp_dn[j]); end
      total++; if (busy !== exp_bs[j])   begin bad++; $display("FAIL oneshot_busy j=%0d got=%b exp=%b", j, busy, exp_bs[j]); end
      total++; if (tick !== exp_tk[j])   begin bad++; $display("FAIL oneshot_tick j=%0d got=%b exp=%b", j, tick, exp_tk[j]); end
      step();
    end
  endtask

  task automatic test_auto();
    int           t;
    logic [W-1:0] ec;
    logic         et, ed;
    do_load(8'd2, 4'd3, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      // a decrement every 4 cycles, visible from observation 5; reload every 2nd decrement
      t  = (j - 1) / 4;
      ec = (t % 2 == 0) ? 8'd2 : 8'd1;
      et = (j >= 5) && (j % 4 == 1);
      ed = (j >= 9) && (j % 8 == 1);
      total++; if (count !== ec)  begin bad++; $display("FAIL auto_count j=%0d got=%0d exp=%0d", j, count, ec); end
      total++; if (tick !== et)   begin bad++; $display("FAIL auto_tick j=%0d got=%b exp=%b", j, tick, et); end
      total++; if (done !== ed)   begin bad++; $display("FAIL auto_done j=%0d got=%b exp=%b", j, done, ed); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL auto_busy j=%0d got=%b exp=1", j, busy); end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL auto_stop busy got=%b exp=0", busy); end
    total++; if (count !== 8'd2) begin bad++; $display("FAIL auto_stop count got=%0d exp=2", count); end
  endtask

  task automatic test_pause();
    int done_j = -1;
    do_load(8'd5, 4'd1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (j >= 4 && j <= 10) begin
        total++; if (count !== 8'd4) begin bad++; $display("FAIL pause_frozen_count j=%0d got=%0d exp=4", j, count); end
        total++; if (tick !== 1'b0)  begin bad++; $display("FAIL pause_frozen_tick j=%0d got=%b exp=0", j, tick); end
      end
      if (done === 1'b1) begin
        done_j = j;
        break;
      end
      pause = (j >= 3) && (j <= 8);
      step();
    end
    pause = 1'b0;
    // unpaused latency would be 5*2+1 = 11; pause adds 7
    total++; if (done_j != 18) begin bad++; $display("FAIL pause_latency got=%0d exp=18", done_j); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pause_busy_at_done got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_stop_terminal();
    do_load(8'd1, 4'd2, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      total++; if (done !== 1'b0)  begin bad++; $display("FAIL stopterm_pre_done j=%0d got=%b exp=0", j, done); end
      total++; if (count !== 8'd1) begin bad++; $display("FAIL stopterm_pre_count j=%0d got=%0d exp=1", j, count); end
      if (j < 3) step();
    end
    stop = 1'b1;  // lands on the terminal-decrement cycle
    step();
    stop = 1'b0;
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL stopterm_busy got=%b exp=0", busy); end
    total++; if (count !== 8'd1)      begin bad++; $display("FAIL stopterm_count got=%0d exp=1", count); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL stopterm_done got=%b exp=0", done); end
    total++; if (tick !== 1'b0)       begin bad++; $display("FAIL stopterm_tick got=%b exp=0", tick); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL stopterm_load_ready got=%b exp=1", load_ready); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stopterm_late_done got=%b exp=0", done); end
  endtask

  task automatic test_zero_and_busy_load();
    int           done_j = -1;
    logic [W-1:0] ec;
    do_load(8'd0, 4'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", count); end
    do_load(8'd7, 4'd1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    // hostile configuration offered throughout the run
    load_valid    = 1'b1;
    load_value    = 8'd3;
    load_prescale = 4'd0;
    load_auto     = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      if (done === 1'b1) begin
        done_j = j;
        break;
      end
      ec = 8'(7 - (j - 1) / 2);
      total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL busyload_ready j=%0d got=%b exp=0", j, load_ready); end
      total++; if (count !== ec)        begin bad++; $display("FAIL busyload_count j=%0d got=%0d exp=%0d", j, count, ec); end
      step();
    end
    load_valid = 1'b0;
    total++; if (done_j != 15)   begin bad++; $display("FAIL busyload_latency got=%0d exp=15", done_j); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL busyload_final_count got=%0d exp=0", count); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busyload_oneshot_kept busy got=%b exp=0", busy); end
  endtask

  task automatic test_rst_mid_run();
    do_load(8'd6, 4'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    total++; if (count !== 8'd4) begin bad++; $display("FAIL rstrun_pre_count got=%0d exp=4", count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (count !== 8'd0)      begin bad++; $display("FAIL rstrun_count got=%0d exp=0", count); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rstrun_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL rstrun_done got=%b exp=0", done); end
    total++; if (tick !== 1'b0)       begin bad++; $display("FAIL rstrun_tick got=%b exp=0", tick); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rstrun_load_ready got=%b exp=1", load_ready); end
    do_load(8'd9, 4'd0, 1'b0);
    total++; if (count !== 8'd9) begin bad++; $display("FAIL rstrun_reload count got=%0d exp=9", count); end
    // reset while held
    start = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b1;
    step();
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rsthold_pre_busy got=%b exp=1", busy); end
    rst = 1'b1;
    step();
    rst   = 1'b0;
    pause = 1'b0;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rsthold_busy got=%b exp=0", busy); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL rsthold_count got=%0d exp=0", count); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL rsthold_done got=%b exp=0", done); end
  endtask

  task automatic test_random();
    // Model: timer is either idle or active (optionally held); while active and not
    // held, cycles accumulate toward a period of prescale+1, each full period is one decrement.
    logic         m_active, m_held, m_auto, m_done, m_tick;
    logic [W-1:0] m_count, m_reload;
    int           m_period, m_elapsed;
    m_active = 0; m_held = 0; m_auto = 0; m_done = 0; m_tick = 0;
    m_count = '0; m_reload = '0; m_period = 1; m_elapsed = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      load_valid    = ($urandom_range(0, 6) == 0);
      load_value    = W'($urandom_range(0, 6));
      load_prescale = P'($urandom_range(0, 3));
      load_auto     = $urandom_range(0, 1);
      start         = ($urandom_range(0, 4) == 0);
      stop          = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;

      if (rst) begin
        m_active = 0; m_held = 0; m_auto = 0; m_done = 0; m_tick = 0;
        m_count = '0; m_reload = '0; m_period = 1; m_elapsed = 0;
      end else begin
        m_done = 0;
        m_tick = 0;
        if (!m_active) begin
          if (load_valid) begin
            m_count  = load_value;
            m_reload = load_value;
            m_period = int'(load_prescale) + 1;
            m_auto   = load_auto;
          end else if (start && m_count != 0) begin
            m_active  = 1;
            m_held    = 0;
            m_elapsed = 0;
          end
        end else if (stop) begin
          m_active  = 0;
          m_held    = 0;
          m_elapsed = 0;
        end else if (m_held) begin
          if (!pause) m_held = 0;
        end else if (pause) begin
          m_held = 1;
        end else begin
          m_elapsed++;
          if (m_elapsed == m_period) begin
            m_elapsed = 0;
            m_tick    = 1;
            if (m_count == 1) begin
              m_done = 1;
              if (m_auto) m_count = m_reload;
              else begin
                m_count  = 0;
                m_active = 0;
              end
            end else begin
              m_count = m_count - 1;
            end
          end
        end
      end

      step();
      total++; if (count !== m_count)     begin bad++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, m_count); end
      total++; if (busy !== m_active)     begin bad++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_active); end
      total++; if (done !== m_done)       begin bad++; $display("FAIL rand_done c=%0d got=%b exp=%b", c, done, m_done); end
      total++; if (tick !== m_tick)       begin bad++; $display("FAIL rand_tick c=%0d got=%b exp=%b", c, tick, m_tick); end
      total++; if (load_ready !== !m_active) begin bad++; $display("FAIL rand_load_ready c=%0d got=%b exp=%b", c, load_ready, !m_active); end
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_oneshot();
    test_auto();
    test_pause();
    test_stop_terminal();
    test_zero_and_busy_load();
    test_rst_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
